// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The burst helper resolves the per-grant beat limit for either build of FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STALL_W = 16;

  // Beats allowed per grant: MAX_BURST when bursting is built in, otherwise one.
  function automatic logic [7:0] burst_limit(input bit burst_en, input int max_burst);
    return burst_en ? 8'(max_burst) : 8'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester strictly after last_id,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_id,
  output logic [$clog2(NUM_REQ)-1:0] pick_id,
  output logic                       pick_valid
);

  localparam int ID_W = $clog2(NUM_REQ);

  // cand_id[k] is the requester at search distance k+1 from last_id.
  logic [ID_W-1:0] cand_id [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_id[gi] = ID_W'((int'(last_id) + gi + 1) % NUM_REQ);
    end
  endgenerate

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    // Walk farthest-first so the nearest valid candidate is the last write.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand_id[k]]) begin
        pick_valid = 1'b1;
        pick_id    = cand_id[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ requesters onto one async-FIFO write port.
// Define FIFO_ARB_BURST_EN to allow up to MAX_BURST beats per grant; default is one beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [15:0]                   stall_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);

`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam logic [7:0] BURST_LIMIT = burst_limit(BURST_EN, MAX_BURST);

  arb_state_t           state_reg;
  logic                 grant_valid_reg;
  logic [ID_W-1:0]      grant_id_reg;
  logic [ID_W-1:0]      last_id_reg;
  logic [7:0]           beat_cnt_reg;
  logic [STALL_W-1:0]   stall_cnt_reg;

  logic [ID_W-1:0]      pick_id;
  logic                 pick_valid;
  logic                 cur_valid;
  logic                 xfer;
  logic                 stall;
  logic                 release_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_id    (last_id_reg),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  assign cur_valid     = req_valid[grant_id_reg];
  assign xfer          = grant_valid_reg & cur_valid & ~fifo_wr_full;
  assign stall         = grant_valid_reg & cur_valid & fifo_wr_full;
  // A dropped request releases even with zero beats taken; a full FIFO never does.
  assign release_grant = grant_valid_reg &
                         (~cur_valid | (xfer & ((beat_cnt_reg + 8'd1) >= BURST_LIMIT)));

  always_comb begin
    req_ready               = '0;
    req_ready[grant_id_reg] = xfer;
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = grant_valid_reg ? req_data[grant_id_reg*DATA_WIDTH +: DATA_WIDTH]
                                        : '0;
  assign grant_valid  = grant_valid_reg;
  assign grant_id     = grant_id_reg;
  assign stall_cnt    = stall_cnt_reg;

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_reg       <= IDLE;
      grant_valid_reg <= 1'b0;
      grant_id_reg    <= '0;
      last_id_reg     <= ID_W'(NUM_REQ - 1);
      beat_cnt_reg    <= 8'd0;
      stall_cnt_reg   <= '0;
    end else begin
      if (stall && (stall_cnt_reg != {STALL_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg       <= GRANT;
            grant_valid_reg <= 1'b1;
            grant_id_reg    <= pick_id;
            beat_cnt_reg    <= 8'd0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            state_reg       <= IDLE;
            grant_valid_reg <= 1'b0;
            last_id_reg     <= grant_id_reg;
            beat_cnt_reg    <= 8'd0;
          end else if (xfer) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg       <= IDLE;
          grant_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
